writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//   Consumer end of the memory/writeback pipeline latch: takes the latched w_* fields,
//   selects the register-file write value, and drives the register-file write port.
//   Tracks processor halt as a sticky state, counts retired instructions, and holds a
//   registered copy of the last committed write so decode can forward from it.
//   Sits between the mem/writeback latch outputs and the register file / hazard unit.
// PARAMETERS
//   WORD_W   32  data word width
//   REG_W    5   register index width
//   COUNT_W  32  retired-instruction counter width
// PORTS
//   CLK          in   1        clock, all state updates on rising edge
//   RST          in   1        asynchronous reset, active-high
//   w_valid      in   1        latch holds a real instruction (0 = bubble/flushed slot)
//   w_RegWrite   in   1        instruction writes a register
//   w_halt       in   1        instruction is HALT
//   w_MemToReg   in   2        write-data select
//   w_regWSEL    in   REG_W    destination register
//   w_port_o     in   WORD_W   ALU result
//   w_dmemload   in   WORD_W   data-memory load value
//   w_pc4        in   WORD_W   PC+4 (link value)
//   w_lui        in   WORD_W   LUI immediate, already shifted
//   wb_WEN       out  1        register-file write enable
//   wb_wsel      out  REG_W    register-file write index
//   wb_wdat      out  WORD_W   register-file write data
//   fwd_valid    out  1        fwd_sel/fwd_dat hold a committed write
//   fwd_sel      out  REG_W    last committed destination
//   fwd_dat      out  WORD_W   last committed data
//   halt         out  1        sticky halt indication
//   retired      out  COUNT_W  retired-instruction count
// BEHAVIOUR
//   - Clock CLK, reset RST: one clock; reset is asynchronous and active-high.
//   - Data select (combinational): MemToReg 0=w_port_o, 1=w_dmemload, 2=w_pc4, 3=w_lui.
//   - Register write (combinational, zero latency):
//     wb_WEN = w_valid & w_RegWrite & (w_regWSEL!=0) & (state==RUN).
//   - wb_wsel and wb_wdat always reflect the inputs; they are don't-care when wb_WEN=0.
//   - Writes to r0 are never committed: wb_WEN=0, and fwd_* are not updated.
//   - FSM: RUN, HALTED. RUN->HALTED on an edge with w_valid & w_halt. HALTED exits only
//     on RST.
//   - halt = (state==HALTED), so halt asserts one cycle after HALT is presented.
//   - A HALT instruction that also has w_RegWrite=1 still commits its write (state is
//     RUN that cycle).
//   - In HALTED, wb_WEN=0, retired frozen, fwd_* frozen.
//   - Retire counter: +1 on each edge with w_valid & (state==RUN), whether or not the
//     instruction writes a register; HALT itself counts.
//   - The counter saturates at all-ones; it does not wrap.
//   - Forward register: on each edge with wb_WEN=1, fwd_sel<=w_regWSEL,
//     fwd_dat<=selected data, fwd_valid<=1.
//   - Otherwise fwd_* hold. fwd_valid is never cleared except by reset.
//   - Bubbles (w_valid=0) have no effect, even if the other inputs are nonzero.
//   - Reset values: state RUN, halt 0, retired 0, fwd_valid 0, fwd_sel 0, fwd_dat 0.
//     Reset mid-HALTED returns to RUN immediately, asynchronously.
//   - wb_WEN is 0 while RST is high.
// TESTING
//   - Select: valid, RegWrite, sel=5, MemToReg 0..3 with port_o=0x11, dmemload=0x22,
//     pc4=0x33, lui=0x44 -> wb_wdat 0x11/0x22/0x33/0x44, wb_WEN=1.
//   - Same four also -> fwd_sel=5, fwd_dat updated the following cycle.
//   - r0 guard: RegWrite, sel=0, data 0xDEAD -> wb_WEN=0; fwd_* unchanged;
//     retired increments by 1.
//   - Bubble: w_valid=0 with RegWrite=1, halt=1, sel=7 -> wb_WEN=0, halt stays 0,
//     retired unchanged.
//   - Halt: 3 valid instrs, then HALT with RegWrite sel=2 data 0x55 -> write committed,
//     halt=1 the next cycle, retired=4.
//   - After halt: later valid writes give wb_WEN=0, and retired stays 4.
//   - Reset mid-halt: assert RST asynchronously in HALTED -> halt=0, retired=0,
//     fwd_valid=0 before the next edge.
//   - Reset mid-halt, continued: after release, a valid write to sel=3 commits normally.
//   - Saturation (COUNT_W=4): 20 valid non-halt instrs -> retired=15, held.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: selects register-file write data, tracks sticky halt,
// counts retired instructions and keeps the last committed write for forwarding.
module writeback_stage #(
  parameter int WORD_W  = 32,
  parameter int REG_W   = 5,
  parameter int COUNT_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               w_valid,
  input  logic               w_RegWrite,
  input  logic               w_halt,
  input  logic [1:0]         w_MemToReg,
  input  logic [REG_W-1:0]   w_regWSEL,
  input  logic [WORD_W-1:0]  w_port_o,
  input  logic [WORD_W-1:0]  w_dmemload,
  input  logic [WORD_W-1:0]  w_pc4,
  input  logic [WORD_W-1:0]  w_lui,
  output logic               wb_WEN,
  output logic [REG_W-1:0]   wb_wsel,
  output logic [WORD_W-1:0]  wb_wdat,
  output logic               fwd_valid,
  output logic [REG_W-1:0]   fwd_sel,
  output logic [WORD_W-1:0]  fwd_dat,
  output logic               halt,
  output logic [COUNT_W-1:0] retired
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e              state_q, state_d;
  logic [COUNT_W-1:0]  retired_q, retired_d;
  logic                fwd_valid_q, fwd_valid_d;
  logic [REG_W-1:0]    fwd_sel_q, fwd_sel_d;
  logic [WORD_W-1:0]   fwd_dat_q, fwd_dat_d;
  logic                run;
  logic [WORD_W-1:0]   wdat;

  assign run = (state_q == RUN);

  always_comb begin
    wdat = w_port_o;
    unique case (w_MemToReg)
      2'd0: wdat = w_port_o;
      2'd1: wdat = w_dmemload;
      2'd2: wdat = w_pc4;
      2'd3: wdat = w_lui;
    endcase
  end

  assign wb_wsel = w_regWSEL;
  assign wb_wdat = wdat;
  // r0 is hardwired zero, so its writes are dropped here, not in the regfile
  assign wb_WEN  = w_valid & w_RegWrite & (|w_regWSEL) & run & ~RST;

  always_comb begin
    state_d     = state_q;
    retired_d   = retired_q;
    fwd_valid_d = fwd_valid_q;
    fwd_sel_d   = fwd_sel_q;
    fwd_dat_d   = fwd_dat_q;
    if (run && w_valid) begin
      if (w_halt)
        state_d = HALTED;
      if (!(&retired_q))
        retired_d = retired_q + 1'b1;
    end
    if (wb_WEN) begin
      fwd_valid_d = 1'b1;
      fwd_sel_d   = w_regWSEL;
      fwd_dat_d   = wdat;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RUN;
      retired_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_sel_q   <= '0;
      fwd_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      retired_q   <= retired_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_sel_q   <= fwd_sel_d;
      fwd_dat_q   <= fwd_dat_d;
    end
  end

  assign halt      = (state_q == HALTED);
  assign retired   = retired_q;
  assign fwd_valid = fwd_valid_q;
  assign fwd_sel   = fwd_sel_q;
  assign fwd_dat   = fwd_dat_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage; a second instance with a 4-bit
// counter shares the inputs to exercise saturation.
module tb_writeback_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        w_valid, w_RegWrite, w_halt;
  logic [1:0]  w_MemToReg;
  logic [4:0]  w_regWSEL;
  logic [31:0] w_port_o, w_dmemload, w_pc4, w_lui;

  logic        wb_WEN, fwd_valid, halt;
  logic [4:0]  wb_wsel, fwd_sel;
  logic [31:0] wb_wdat, fwd_dat, retired;

  logic        s_WEN, s_fwd_valid, s_halt;
  logic [4:0]  s_wsel, s_fwd_sel;
  logic [31:0] s_wdat, s_fwd_dat;
  logic [3:0]  s_retired;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  writeback_stage dut (
    .CLK(CLK), .RST(RST), .w_valid(w_valid), .w_RegWrite(w_RegWrite),
    .w_halt(w_halt), .w_MemToReg(w_MemToReg), .w_regWSEL(w_regWSEL),
    .w_port_o(w_port_o), .w_dmemload(w_dmemload), .w_pc4(w_pc4),
    .w_lui(w_lui), .wb_WEN(wb_WEN), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .fwd_valid(fwd_valid), .fwd_sel(fwd_sel), .fwd_dat(fwd_dat),
    .halt(halt), .retired(retired)
  );

  writeback_stage #(.COUNT_W(4)) sat (
    .CLK(CLK), .RST(RST), .w_valid(w_valid), .w_RegWrite(w_RegWrite),
    .w_halt(w_halt), .w_MemToReg(w_MemToReg), .w_regWSEL(w_regWSEL),
    .w_port_o(w_port_o), .w_dmemload(w_dmemload), .w_pc4(w_pc4),
    .w_lui(w_lui), .wb_WEN(s_WEN), .wb_wsel(s_wsel), .wb_wdat(s_wdat),
    .fwd_valid(s_fwd_valid), .fwd_sel(s_fwd_sel), .fwd_dat(s_fwd_dat),
    .halt(s_halt), .retired(s_retired)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic h,
                       input logic [1:0] m, input logic [4:0] sel,
                       input logic [31:0] po);
    w_valid    = v;
    w_RegWrite = rw;
    w_halt     = h;
    w_MemToReg = m;
    w_regWSEL  = sel;
    w_port_o   = po;
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    step();
    #2 RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  logic [31:0] exp_dat [4];

  initial begin
    exp_dat[0] = 32'h11; exp_dat[1] = 32'h22;
    exp_dat[2] = 32'h33; exp_dat[3] = 32'h44;
    RST = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2'd0, 5'd5, 32'h11);
    w_dmemload = 32'h22; w_pc4 = 32'h33; w_lui = 32'h44;
    #3;
    check("rst_wen", wb_WEN, 0);
    check("rst_halt", halt, 0);
    check("rst_retired", retired, 0);
    check("rst_fwd_valid", fwd_valid, 0);
    check("rst_fwd_sel", fwd_sel, 0);
    check("rst_fwd_dat", fwd_dat, 0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'h11);
    @(negedge CLK);
    RST = 1'b0;

    for (int m = 0; m < 4; m++) begin
      drive(1'b1, 1'b1, 1'b0, 2'(m), 5'd5, 32'h11);
      #1;
      check($sformatf("sel%0d_wen", m), wb_WEN, 1);
      check($sformatf("sel%0d_wdat", m), wb_wdat, exp_dat[m]);
      check($sformatf("sel%0d_wsel", m), wb_wsel, 5);
      step();
      check($sformatf("sel%0d_fwd_sel", m), fwd_sel, 5);
      check($sformatf("sel%0d_fwd_dat", m), fwd_dat, exp_dat[m]);
      check($sformatf("sel%0d_fwd_valid", m), fwd_valid, 1);
    end
    check("sel_retired", retired, 4);

    drive(1'b1, 1'b1, 1'b0, 2'd0, 5'd0, 32'hDEAD);
    #1 check("r0_wen", wb_WEN, 0);
    step();
    check("r0_fwd_sel", fwd_sel, 5);
    check("r0_fwd_dat", fwd_dat, 32'h44);
    check("r0_retired", retired, 5);

    drive(1'b0, 1'b1, 1'b1, 2'd0, 5'd7, 32'h99);
    #1 check("bub_wen", wb_WEN, 0);
    step();
    check("bub_halt", halt, 0);
    check("bub_retired", retired, 5);
    check("bub_fwd_sel", fwd_sel, 5);

    drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0);
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'd0, 5'd1, 32'h1);
      step();
    end
    check("pre_halt_retired", retired, 3);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 5'd2, 32'h55);
    #1;
    check("halt_wen", wb_WEN, 1);
    check("halt_same_cycle", halt, 0);
    step();
    check("halt_set", halt, 1);
    check("halt_retired", retired, 4);
    check("halt_fwd_sel", fwd_sel, 2);
    check("halt_fwd_dat", fwd_dat, 32'h55);

    drive(1'b1, 1'b1, 1'b0, 2'd0, 5'd6, 32'h66);
    #1 check("halted_wen", wb_WEN, 0);
    step();
    check("halted_retired", retired, 4);
    check("halted_fwd_sel", fwd_sel, 2);
    check("halted_sticky", halt, 1);

    #2 RST = 1'b1;
    #1;
    check("arst_halt", halt, 0);
    check("arst_retired", retired, 0);
    check("arst_fwd_valid", fwd_valid, 0);
    check("arst_wen", wb_WEN, 0);
    @(negedge CLK);
    RST = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 2'd0, 5'd3, 32'h77);
    #1 check("post_rst_wen", wb_WEN, 1);
    step();
    check("post_rst_fwd_sel", fwd_sel, 3);
    check("post_rst_fwd_dat", fwd_dat, 32'h77);
    check("post_rst_retired", retired, 1);

    drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0);
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'd0, 5'd1, 32'h1);
      step();
      if (i == 14) check("sat_reach", s_retired, 15);
    end
    check("sat_held", s_retired, 15);
    check("wide_count", retired, 20);
    check("sat_not_halted", s_halt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
